pushbutton_debouncer_mc: RTL and testbench

Multi-channel, parametrised debouncer for front-panel push-buttons and other slow, glitchy, asynchronous inputs. Each channel synchronises its raw input and debounces it against a runtime-programmable threshold. Each channel outputs a clean level plus press and release strobes, and adds long-press detection against a shared prescaled timebase. It sits between board-level pins and the housekeeping/register logic, replacing one single-channel debouncer per pin.

---
 rtl/pushbutton_debouncer_mc.sv | 107 ++++++++++
 tb/tb_pushbutton_debouncer_mc.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pushbutton_debouncer_mc.sv
// Multi-channel button debouncer: 2-FF sync, per-channel debounce against cfg_deb_i,
// press/release strobes and long-press detection on a shared prescaled tick.
module pushbutton_debouncer_mc #(
    parameter int CH      = 4,
    parameter int CW      = 16,
    parameter int ACT_LOW = 1,
    parameter int PRE_W   = 16,
    parameter int LW      = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [CH-1:0] dat_i,
    input  logic [CH-1:0] en_i,
    input  logic [CW-1:0] cfg_deb_i,
    input  logic [LW-1:0] cfg_long_i,
    output logic [CH-1:0] state_o,
    output logic [CH-1:0] down_o,
    output logic [CH-1:0] up_o,
    output logic [CH-1:0] long_o,
    output logic [CH-1:0] held_o
);

    logic [CH-1:0]          raw;
    logic [CH-1:0]          s0_q, s1_q;
    logic [CH-1:0]          state_q, state_d;
    logic [CH-1:0]          down_q, down_d, up_q, up_d;
    logic [CH-1:0]          long_q, long_d, held_q, held_d;
    logic [CH-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [CH-1:0][LW-1:0]  hold_q, hold_d;
    logic [PRE_W-1:0]       pre_q;
    logic                   tick;
    logic                   long_en;

    assign raw     = (ACT_LOW != 0) ? ~dat_i : dat_i;
    assign tick    = &pre_q;
    assign long_en = (cfg_long_i != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        down_d  = '0;
        up_d    = '0;
        long_d  = '0;
        held_d  = '0;
        for (int n = 0; n < CH; n++) begin
            if (!en_i[n]) begin
                state_d[n] = 1'b0;
                cnt_d[n]   = '0;
                hold_d[n]  = '0;
            end else begin
                // >= compare lets a lowered threshold take effect on an in-flight count
                if (state_q[n] == s1_q[n]) begin
                    cnt_d[n] = '0;
                end else if (cnt_q[n] >= cfg_deb_i) begin
                    state_d[n] = ~state_q[n];
                    cnt_d[n]   = '0;
                    down_d[n]  = ~state_q[n];
                    up_d[n]    = state_q[n];
                end else begin
                    cnt_d[n] = cnt_q[n] + CW'(1);
                end

                if (!state_q[n]) begin
                    hold_d[n] = '0;
                end else if (tick && (hold_q[n] != '1)) begin
                    hold_d[n] = hold_q[n] + LW'(1);
                    long_d[n] = long_en && state_d[n] && (hold_d[n] == cfg_long_i);
                end
                held_d[n] = state_d[n] && long_en && (hold_d[n] >= cfg_long_i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s0_q    <= '0;
            s1_q    <= '0;
            state_q <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            pre_q   <= '0;
            down_q  <= '0;
            up_q    <= '0;
            long_q  <= '0;
            held_q  <= '0;
        end else begin
            s0_q    <= raw;
            s1_q    <= s0_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            pre_q   <= pre_q + PRE_W'(1);
            down_q  <= down_d;
            up_q    <= up_d;
            long_q  <= long_d;
            held_q  <= held_d;
        end
    end

    assign state_o = state_q;
    assign down_o  = down_q;
    assign up_o    = up_q;
    assign long_o  = long_q;
    assign held_o  = held_q;

endmodule

// File: tb/tb_pushbutton_debouncer_mc.sv
// Directed bench for pushbutton_debouncer_mc; expected strobe events are queued by the
// stimulus and checked by an independent monitor on the falling edge.
module tb_pushbutton_debouncer_mc;
    localparam int CH = 4, CW = 16, PRE_W = 4, LW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [CH-1:0] dat_i = 4'hF;
    logic [CH-1:0] en_i  = 4'hF;
    logic [CW-1:0] cfg_deb_i  = 16'd10;
    logic [LW-1:0] cfg_long_i = 8'd0;
    logic [CH-1:0] state_o, down_o, up_o, long_o, held_o;

    pushbutton_debouncer_mc #(
        .CH(CH), .CW(CW), .ACT_LOW(1), .PRE_W(PRE_W), .LW(LW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat_i), .en_i(en_i),
        .cfg_deb_i(cfg_deb_i), .cfg_long_i(cfg_long_i),
        .state_o(state_o), .down_o(down_o), .up_o(up_o),
        .long_o(long_o), .held_o(held_o)
    );

    typedef struct packed {
        int         cyc;
        logic [3:0] dn, up, lg, st, hd;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e, mon_a;
    int  cyc = 0, n_chk = 0, n_fail = 0, rst_cyc = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if ((down_o | up_o | long_o) != '0) begin
            n_chk++;
            mon_a = '{cyc, down_o, up_o, long_o, state_o, held_o};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe cyc=%0d dn=%b up=%b lg=%b st=%b hd=%b",
                         cyc, down_o, up_o, long_o, state_o, held_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_a !== mon_e) begin
                    n_fail++;
                    $display("FAIL event got cyc=%0d dn=%b up=%b lg=%b st=%b hd=%b, want cyc=%0d dn=%b up=%b lg=%b st=%b hd=%b",
                             mon_a.cyc, mon_a.dn, mon_a.up, mon_a.lg, mon_a.st, mon_a.hd,
                             mon_e.cyc, mon_e.dn, mon_e.up, mon_e.lg, mon_e.st, mon_e.hd);
                end
            end
        end else if (exp_q.size() != 0 && cyc >= exp_q[0].cyc) begin
            n_chk++;
            n_fail++;
            mon_e = exp_q.pop_front();
            $display("FAIL missing_event at cyc=%0d got no strobe, want dn=%b up=%b lg=%b",
                     mon_e.cyc, mon_e.dn, mon_e.up, mon_e.lg);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic push(input int c, input logic [3:0] dn, input logic [3:0] up,
                        input logic [3:0] lg, input logic [3:0] st, input logic [3:0] hd);
        exp_q.push_back('{c, dn, up, lg, st, hd});
    endtask

    task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // First hold increment is the first tick edge after the press edge t; the 3rd tick raises long.
    function automatic int long_cyc3(input int t, input int r);
        int e = t + 1;
        while (((e - r) % 16) != 0) e++;
        return e + 32;
    endfunction

    int c, t;

    initial begin
        step(3);
        rst_i   = 1'b0;
        rst_cyc = cyc;
        chk("reset_outputs", {state_o, down_o, up_o, long_o, held_o}, 20'h0);

        // clean press/release on ch0, latency cfg_deb_i + 2 after sampling
        c = cyc; dat_i[0] = 1'b0; push(c + 13, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);
        step(20);
        c = cyc; dat_i[0] = 1'b1; push(c + 13, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
        step(20);

        // glitches shorter than threshold, then the shortest low that toggles
        dat_i[1] = 1'b0; step(8);  dat_i[1] = 1'b1; step(20);
        chk("glitch8_state", {28'h0, state_o}, {28'h0, 4'h0});
        dat_i[1] = 1'b0; step(10); dat_i[1] = 1'b1; step(20);
        chk("glitch10_state", {28'h0, state_o}, {28'h0, 4'h0});
        c = cyc; dat_i[1] = 1'b0; push(c + 13, 4'h2, 4'h0, 4'h0, 4'h2, 4'h0);
        step(11);
        c = cyc; dat_i[1] = 1'b1; push(c + 13, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
        step(20);

        // zero threshold: two-cycle latency
        cfg_deb_i = 16'd0;
        c = cyc; dat_i[0] = 1'b0; push(c + 3, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0);
        step(10);
        c = cyc; dat_i[0] = 1'b1; push(c + 3, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
        step(10);
        cfg_deb_i = 16'd10;

        // long press with long detect off
        c = cyc; dat_i[3] = 1'b0; push(c + 13, 4'h8, 4'h0, 4'h0, 4'h8, 4'h0);
        step(30);
        chk("longoff_held_mid", {16'h0, held_o}, 20'h0);
        step(30);
        chk("longoff_held_late", {16'h0, held_o}, 20'h0);
        c = cyc; dat_i[3] = 1'b1; push(c + 13, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0);
        step(20);

        // long press on ch2 with threshold 3 ticks
        cfg_long_i = 8'd3;
        c = cyc; t = c + 13; dat_i[2] = 1'b0;
        push(t, 4'h4, 4'h0, 4'h0, 4'h4, 4'h0);
        push(long_cyc3(t, rst_cyc), 4'h0, 4'h0, 4'h4, 4'h4, 4'h4);
        step(20);
        chk("long_held_early", {16'h0, held_o}, 20'h0);
        step(70);
        chk("long_held_after", {16'h0, held_o}, {16'h0, 4'h4});
        step(10);
        c = cyc; dat_i[2] = 1'b1; push(c + 13, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0);
        step(20);
        chk("long_held_released", {16'h0, held_o}, 20'h0);
        cfg_long_i = 8'd0;

        // disable while pressed, re-enable with button still held
        c = cyc; dat_i[3] = 1'b0; push(c + 13, 4'h8, 4'h0, 4'h0, 4'h8, 4'h0);
        step(20);
        en_i[3] = 1'b0;
        step(1);
        chk("disable_outputs", {state_o, down_o, up_o, long_o, held_o}, 20'h0);
        step(9);
        c = cyc; en_i[3] = 1'b1; push(c + 11, 4'h8, 4'h0, 4'h0, 4'h8, 4'h0);
        step(20);
        c = cyc; dat_i[3] = 1'b1; push(c + 13, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0);
        step(20);

        // simultaneous presses, then reset mid-count with all buttons held
        c = cyc; dat_i = 4'hC; push(c + 13, 4'h3, 4'h0, 4'h0, 4'h3, 4'h0);
        step(20);
        dat_i = 4'h0;
        step(5);
        rst_i = 1'b1;
        step(1);
        chk("midreset_outputs", {state_o, down_o, up_o, long_o, held_o}, 20'h0);
        step(1);
        rst_i = 1'b0; rst_cyc = cyc;
        push(cyc + 13, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0);
        step(20);
        c = cyc; dat_i = 4'hF; push(c + 13, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        step(20);

        step(5);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_leftover got %0d pending events want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
